// File: rtl/hls_run_pkg.sv
// hls_run_pkg: types shared by the run sequencer and its result FIFO.
// A result record is {res_hdr_t, cycles}; cycles width is set per instance by CNT_W.
package hls_run_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_LAUNCH, S_WAIT, S_REPORT, S_DONE} state_e;
    typedef enum logic [1:0] {ST_OK = 2'd0, ST_TIMEOUT = 2'd1, ST_ABORTED = 2'd2} status_e;
    typedef struct packed {
        logic [2:0] ch;
        status_e    status;
    } res_hdr_t;
    localparam int HDR_W = $bits(res_hdr_t);
endpackage

// File: rtl/hls_run_fifo.sv
// hls_run_fifo: synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module hls_run_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: launches timed runs on selected channels and queues {ch, status, cycles} records.
// Optional min/max/sum statistics of OK runs when HLS_RUN_STATS_EN is defined.
module hls_run_sequencer import hls_run_pkg::*; #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 200000000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_runs,
    input  logic [NUM_CH-1:0] cmd_ch_mask,
    input  logic              abort,
    output logic [NUM_CH-1:0] start_port,
    input  logic [NUM_CH-1:0] done_port,
    output logic [NUM_CH-1:0] dut_reset,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2:0]        res_ch,
    output logic [1:0]        res_status,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              busy
`ifdef HLS_RUN_STATS_EN
  , output logic [CNT_W-1:0]  stat_min,
    output logic [CNT_W-1:0]  stat_max,
    output logic [CNT_W+15:0] stat_sum
`endif
);
    state_e            state, state_n;
    status_e           rec_st, rec_st_n;
    logic [NUM_CH-1:0] mask, mask_n, ch_vec, rem_mask;
    logic [15:0]       runs, runs_n, run_cnt, run_cnt_n;
    logic [2:0]        ch, ch_n, low_idx;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic              abort_pend, abort_pend_n, done_hit, timed_out, push, full, empty;
    res_hdr_t          hdr_in, hdr_out;
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) if (mask[i]) low_idx = 3'(i);
    end
    assign ch_vec     = NUM_CH'(1) << ch;
    assign rem_mask   = mask & ~ch_vec;
    assign done_hit   = |(done_port & ch_vec);
    assign cnt_inc    = &cnt ? cnt : cnt + CNT_W'(1);
    assign timed_out  = cnt_inc >= CNT_W'(TIMEOUT_CYC);
    assign cmd_ready  = state == S_IDLE;
    assign busy       = !cmd_ready;
    assign start_port = state == S_LAUNCH ? ch_vec : '0;
    assign dut_reset  = (state == S_WAIT && !done_hit && !abort && timed_out) ? ch_vec : '0;
    assign push       = state == S_REPORT && !full;
    always_comb begin
        state_n      = state;
        mask_n       = mask;
        runs_n       = runs;
        run_cnt_n    = run_cnt;
        ch_n         = ch;
        cnt_n        = cnt;
        rec_st_n     = rec_st;
        abort_pend_n = abort_pend;
        case (state)
            S_IDLE: if (cmd_valid) begin
                mask_n       = cmd_ch_mask;
                runs_n       = cmd_runs == 16'd0 ? 16'd1 : cmd_runs;
                abort_pend_n = 1'b0;
                state_n      = cmd_ch_mask == '0 ? S_DONE : S_SELECT;
            end
            S_SELECT: begin
                ch_n      = low_idx;
                run_cnt_n = runs;
                state_n   = abort ? S_DONE : S_LAUNCH;
            end
            S_LAUNCH: begin
                cnt_n    = CNT_W'(1);
                rec_st_n = ST_OK;
                state_n  = abort ? S_DONE : done_hit ? S_REPORT : S_WAIT;
            end
            // An abort keeps the count of the cycle it arrived in; done wins over abort and timeout.
            S_WAIT: begin
                cnt_n        = (abort && !done_hit) ? cnt : cnt_inc;
                rec_st_n     = done_hit ? ST_OK : abort ? ST_ABORTED : ST_TIMEOUT;
                abort_pend_n = abort;
                if (done_hit || abort || timed_out) state_n = S_REPORT;
            end
            S_REPORT: begin
                abort_pend_n = abort_pend || abort;
                if (!full) begin
                    if (abort_pend || abort) state_n = S_DONE;
                    else if (run_cnt > 16'd1) begin
                        run_cnt_n = run_cnt - 16'd1;
                        state_n   = S_LAUNCH;
                    end else begin
                        mask_n  = rem_mask;
                        state_n = rem_mask == '0 ? S_DONE : S_SELECT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mask       <= '0;
            runs       <= '0;
            run_cnt    <= '0;
            ch         <= '0;
            cnt        <= '0;
            rec_st     <= ST_OK;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_n;
            mask       <= mask_n;
            runs       <= runs_n;
            run_cnt    <= run_cnt_n;
            ch         <= ch_n;
            cnt        <= cnt_n;
            rec_st     <= rec_st_n;
            abort_pend <= abort_pend_n;
        end
    end
    assign hdr_in.ch     = ch;
    assign hdr_in.status = rec_st;
    hls_run_fifo #(.W(HDR_W + CNT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .din  ({hdr_in, cnt}),
        .pop  (res_ready),
        .dout ({hdr_out, res_cycles}),
        .full (full),
        .empty(empty)
    );
    assign res_valid  = !empty;
    assign res_ch     = hdr_out.ch;
    assign res_status = hdr_out.status;
`ifdef HLS_RUN_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_min <= '1;
            stat_max <= '0;
            stat_sum <= '0;
        end else if (state == S_IDLE && cmd_valid) begin
            stat_min <= '1;
            stat_max <= '0;
            stat_sum <= '0;
        end else if (push && rec_st == ST_OK) begin
            if (cnt < stat_min) stat_min <= cnt;
            if (cnt > stat_max) stat_max <= cnt;
            stat_sum <= stat_sum + (CNT_W+16)'(cnt);
        end
    end
`endif
endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed and random batches against a record-list reference model.
// Build with HLS_RUN_STATS_EN defined to also check the statistics outputs.
module tb_hls_run_sequencer;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int TO  = 50;
    localparam int FD  = 2;

    logic            clock = 1'b0;
    logic            reset, cmd_valid, cmd_ready, abort, res_valid, res_ready, busy;
    logic [15:0]     cmd_runs;
    logic [NCH-1:0]  cmd_ch_mask, start_port, done_port, dut_reset;
    logic [2:0]      res_ch;
    logic [1:0]      res_status;
    logic [CW-1:0]   res_cycles;
`ifdef HLS_RUN_STATS_EN
    logic [CW-1:0]   stat_min, stat_max;
    logic [CW+15:0]  stat_sum;
`endif

    int total = 0, bad = 0;
    int lch_q[$], dly_q[$], fd_q[$];
    logic [20:0] exp_q[$];
    int launched, popped, exp_launch, since_abort, abort_at = 0, rr_mode = 0;
    bit act = 0;
    int act_ch, act_d, el;
    logic [15:0] smin, smax;
    logic [31:0] ssum;

    always #5 clock = ~clock;

    hls_run_sequencer #(.NUM_CH(NCH), .CNT_W(CW), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_runs(cmd_runs), .cmd_ch_mask(cmd_ch_mask), .abort(abort),
        .start_port(start_port), .done_port(done_port), .dut_reset(dut_reset),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_status(res_status), .res_cycles(res_cycles), .busy(busy)
`ifdef HLS_RUN_STATS_EN
      , .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int rand_delay();
        int k;
        k = $urandom_range(0, 9);
        return k == 0 ? 0 : k == 1 ? TO - 1 : k == 2 ? TO + 10 : int'($urandom_range(1, 12));
    endfunction

    // One clock cycle of channel responders plus scoreboard; entered and left 1ns after a rising edge.
    task automatic step();
        logic [NCH-1:0] exp_dr;
        logic [20:0] e;
        int i;
        exp_dr = '0;
        abort = 1'b0;
        done_port = '0;
        if (since_abort >= 0) since_abort++;
        if (start_port !== '0) begin
            if (launched < lch_q.size()) begin
                chk("start", 32'(start_port), 1 << lch_q[launched]);
                act = 1; act_ch = lch_q[launched]; act_d = dly_q[launched]; el = 0;
                launched++;
            end else chk("extra_start", 32'(start_port), 0);
        end
        if (act) begin
            if (abort_at != 0 && el == abort_at) begin
                abort = 1'b1; act = 0; since_abort = 0; exp_launch = launched;
                i = launched - 1 - popped;
                exp_q[i] = {3'(act_ch), 2'd2, 16'(abort_at)};
                while (exp_q.size() > i + 1) void'(exp_q.pop_back());
            end else if (el == act_d) begin
                done_port = NCH'(1) << act_ch; act = 0;
            end else if (el == TO - 1) begin
                exp_dr = NCH'(1) << act_ch; act = 0;
            end
        end
        res_ready = rr_mode == 0 ? ($urandom_range(0, 3) != 0) : rr_mode == 2;
        #1;
        if ((dut_reset | exp_dr) != '0) chk("dut_reset", 32'(dut_reset), 32'(exp_dr));
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) chk("extra_rec", 32'(res_valid), 0);
            else begin
                e = exp_q.pop_front();
                popped++;
                chk("rec", 32'({res_ch, res_status, res_cycles}), 32'(e));
                if (e[17:16] == 2'd0) begin
                    if (e[15:0] < smin) smin = e[15:0];
                    if (e[15:0] > smax) smax = e[15:0];
                    ssum += 32'(e[15:0]);
                end
            end
        end
        if (act) el++;
        @(posedge clock); #1;
    endtask

    task automatic start_batch(input logic [NCH-1:0] m, input logic [15:0] r);
        int n, d;
        lch_q.delete(); dly_q.delete(); exp_q.delete();
        launched = 0; popped = 0; since_abort = -1; act = 0;
        smin = '1; smax = '0; ssum = '0;
        n = r == 0 ? 1 : int'(r);
        for (int c = 0; c < NCH; c++)
            if (m[c])
                for (int k = 0; k < n; k++) begin
                    d = fd_q.size() != 0 ? fd_q.pop_front() : rand_delay();
                    lch_q.push_back(c);
                    dly_q.push_back(d);
                    exp_q.push_back(d < TO ? {3'(c), 2'd0, 16'(d + 1)} : {3'(c), 2'd1, 16'(TO)});
                end
        exp_launch = lch_q.size();
        cmd_ch_mask = m; cmd_runs = r; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_batch(input logic [NCH-1:0] m, input logic [15:0] r, input bit hold);
        int budget;
        start_batch(m, r);
        if (hold) begin
            repeat (100) step();
            chk("stall_launches", launched, 3);
            chk("stall_busy", 32'(busy), 1);
            chk("stall_valid", 32'(res_valid), 1);
            rr_mode = 2;
        end
        budget = 0;
        while ((busy || exp_q.size() != 0) && budget < 4000) begin
            step();
            budget++;
        end
        chk("busy_end", 32'(busy), 0);
        chk("pending_recs", exp_q.size(), 0);
        chk("launches", launched, exp_launch);
        chk("no_leftover", 32'(res_valid), 0);
`ifdef HLS_RUN_STATS_EN
        chk("stat_min", 32'(stat_min), 32'(smin));
        chk("stat_max", 32'(stat_max), 32'(smax));
        chk("stat_sum", stat_sum, ssum);
`endif
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_runs = '0; cmd_ch_mask = '0;
        abort = 1'b0; done_port = '0; res_ready = 1'b0;
        repeat (3) @(posedge clock); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_start", 32'(start_port), 0);
        chk("rst_dut_reset", 32'(dut_reset), 0);
`ifdef HLS_RUN_STATS_EN
        chk("rst_stat_min", 32'(stat_min), 32'hffff);
        chk("rst_stat_sum", stat_sum, 0);
`endif
        reset = 1'b0;
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);

        fd_q = '{10};
        run_batch(4'b0001, 16'd1, 1'b0);
        fd_q = '{0, 0, 0, 0};
        run_batch(4'b1010, 16'd2, 1'b0);
        fd_q = '{TO + 10};
        run_batch(4'b0001, 16'd1, 1'b0);
        fd_q = '{TO - 1};
        run_batch(4'b0100, 16'd1, 1'b0);

        rr_mode = 1;
        fd_q = '{3, 3, 3, 3, 3};
        run_batch(4'b0001, 16'd5, 1'b1);

        rr_mode = 2;
        abort_at = 7;
        fd_q = '{TO + 10, TO + 10};
        run_batch(4'b0001, 16'd2, 1'b0);
        chk("abort_busy_low", since_abort, 2);
        abort_at = 0;
        rr_mode = 0;

        run_batch(4'b0000, 16'd3, 1'b0);
        run_batch(4'b1000, 16'd0, 1'b0);

        fd_q = '{4, 8};
        run_batch(4'b0001, 16'd2, 1'b0);
`ifdef HLS_RUN_STATS_EN
        chk("stats_min5", 32'(stat_min), 5);
        chk("stats_max9", 32'(stat_max), 9);
        chk("stats_sum14", stat_sum, 14);
`endif

        repeat (8) run_batch(NCH'($urandom_range(0, 15)), 16'($urandom_range(0, 3)), 1'b0);

        rr_mode = 1;
        fd_q = '{30, 30};
        start_batch(4'b0011, 16'd1);
        repeat (45) step();
        chk("pre_reset_valid", 32'(res_valid), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_start", 32'(start_port), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        lch_q.delete(); dly_q.delete(); exp_q.delete();
        launched = 0; popped = 0; act = 0;
        repeat (5) step();
        chk("post_rst_res_valid", 32'(res_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        rr_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hls_run_sequencer.md
HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of DUT channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, meaning cycle-counter width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 200000000, meaning watchdog limit in cycles (< 2^CNT_W).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning result FIFO entries (power of 2, >= 2).
REQ-005 SHALL have these ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_runs  in  16  runs per selected channel; 0 treated as 1.
- cmd_ch_mask  in  NUM_CH  channels to exercise.
- abort  in  1  synchronous abort of the current batch.
- start_port  out  NUM_CH  one-cycle start pulse per channel.
- done_port  in  NUM_CH  per-channel done pulse.
- dut_reset  out  NUM_CH  one-cycle reset pulse to a timed-out channel.
- res_valid  out  1  result available (FIFO not empty).
- res_ready  in  1  result consumed when high with res_valid.
- res_ch  out  3  channel index.
- res_status  out  2  0=OK, 1=TIMEOUT, 2=ABORTED.
- res_cycles  out  CNT_W  measured cycles.
- busy  out  1  high whenever state != IDLE.

Function
REQ-006 SHALL implement states IDLE, SELECT, LAUNCH, WAIT, REPORT, DONE.
REQ-007 SHALL accept a command in IDLE on cmd_valid&&cmd_ready, latch mask and runs, and go to SELECT; a mask of 0 SHALL go directly to DONE.
REQ-008 SELECT SHALL pick the lowest set bit of the remaining mask, load the run counter, and go to LAUNCH in one cycle.
REQ-009 LAUNCH SHALL assert start_port[ch] for exactly one cycle, set the cycle counter to 1, and go to WAIT.
REQ-010 WAIT SHALL increment the counter each cycle, saturating at all-ones; res_cycles SHALL equal the number of rising edges from the start_port cycle through the done-sampling cycle inclusive.
REQ-011 done_port[ch] high during the LAUNCH cycle SHALL record cycles=1, status OK, and skip WAIT.
REQ-012 done_port bits of unselected channels SHALL be ignored.
REQ-013 A counter reaching TIMEOUT_CYC in WAIT without done SHALL record status TIMEOUT, cycles=TIMEOUT_CYC, and pulse dut_reset[ch] for one cycle.
REQ-014 Done and timeout in the same cycle SHALL record OK.
REQ-015 REPORT SHALL push {ch,status,cycles} when the FIFO is not full; while full it SHALL stall with no loss.
REQ-016 After a push, remaining runs SHALL relaunch in LAUNCH; otherwise the channel is cleared from the mask and the FSM goes to SELECT, or to DONE when the mask is empty.
REQ-017 DONE SHALL last one cycle and return to IDLE.
REQ-018 abort in WAIT SHALL push an ABORTED record with the current count (stalling if full), then go to DONE; abort in any other non-IDLE state SHALL go to DONE after any pending REPORT push completes; abort in IDLE SHALL be ignored.
REQ-019 A simultaneous FIFO push and pop SHALL both occur when full; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-020 Reset SHALL force IDLE, an empty FIFO, and zero counters; start_port=0, dut_reset=0, res_valid=0, busy=0, cmd_ready=1.
REQ-021 Reset asserted mid-batch SHALL discard all pending results, with no start or dut_reset pulse on release.

Configuration
REQ-022 With HLS_RUN_STATS_EN defined, the module SHALL add outputs stat_min, stat_max (CNT_W each) and stat_sum (CNT_W+16), updated on each OK record and cleared on command accept; stat_min SHALL reset to all-ones.
REQ-023 Without HLS_RUN_STATS_EN, these ports and their registers SHALL be absent.

Structure
REQ-024 The shared package hls_run_pkg SHALL hold the state typedef, the status encodings, and the result-record struct.
REQ-025 The result FIFO SHALL be the sub-module hls_run_fifo (synchronous, first-word-fall-through, parameterised width and depth).

Verification
REQ-026 Mask=4'b0001, runs=1, done after 10 cycles -> one record {ch0, OK, 11}.
REQ-027 Mask=4'b1010, runs=2, done in the LAUNCH cycle -> records ch1, ch1, ch3, ch3, all OK with cycles=1, in that order.
REQ-028 TIMEOUT_CYC=50, no done -> {ch0, TIMEOUT, 50} and a dut_reset[0] pulse.
REQ-029 FIFO_DEPTH=2, res_ready=0, runs=5 -> FSM stalls in REPORT after 2 pushes; releasing res_ready yields all 5 records.
REQ-030 abort at WAIT cycle 7 -> {ch, ABORTED, 7}, then busy low within 2 cycles.
REQ-031 Reset pulse mid-WAIT -> res_valid=0 and cmd_ready=1 immediately after reset; with HLS_RUN_STATS_EN, runs of 5 and 9 cycles -> min=5, max=9, sum=14.
